// File: rtl/frame_bram_buffer.sv
// Purpose: single- or double-banked (ping-pong) raster frame store in inferred simple dual-port RAM.
// Latency: read request to out_data is 1 cycle; the last written pixel makes frame_avail visible 1 cycle later.
// Backpressure: writes are dropped while in_full; read requests are ignored while frame_avail is low.
module frame_bram_buffer #(
    parameter int DATA_WIDTH = 1,
    parameter int IM_WIDTH   = 320,
    parameter int IM_HEIGHT  = 240,
    parameter int ADDR_WIDTH = 17,  // 2**ADDR_WIDTH must cover IM_WIDTH*IM_HEIGHT
    parameter int BANKS      = 2    // 1 = single frame, 2 = ping-pong
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_enable,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_full,
    input  logic                  i_out_request,
    output logic                  o_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_last,
    output logic                  o_frame_avail
);

    localparam int N      = IM_WIDTH * IM_HEIGHT;
    localparam int DEPTH  = BANKS * N;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    // Offset of bank 1; only ever added when the bank select is 1 (BANKS=2).
    localparam logic [MEM_AW-1:0]     BANK_OFS  = MEM_AW'(N);
    // Bank selects toggle only in ping-pong mode and stay at 0 otherwise.
    localparam logic                  PING_PONG = (BANKS == 2);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [BANKS-1:0]      r_full;
    logic                  r_out_ready;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_in_full;
    logic                  w_frame_avail;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_wr_wrap;
    logic                  w_rd_wrap;
    logic [MEM_AW-1:0]     w_wr_mem;
    logic [MEM_AW-1:0]     w_rd_mem;
    logic [BANKS-1:0]      w_full_nxt;

    // Handshake flags come straight from the per-bank full bits.
    assign w_in_full     = r_full[r_wr_bank];
    assign w_frame_avail = r_full[r_rd_bank];

    assign w_wr_fire = i_in_enable && !w_in_full;
    assign w_rd_fire = i_out_request && w_frame_avail;
    assign w_wr_wrap = (r_wr_addr == LAST_ADDR);
    assign w_rd_wrap = (r_rd_addr == LAST_ADDR);

    assign w_wr_mem = MEM_AW'(r_wr_addr) + (r_wr_bank ? BANK_OFS : '0);
    assign w_rd_mem = MEM_AW'(r_rd_addr) + (r_rd_bank ? BANK_OFS : '0);

    // Writer marks its bank full on the last pixel, reader frees its bank on the last pixel.
    // Both can never target the same bank in one cycle, so the order here is immaterial.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && w_wr_wrap) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_fire && w_rd_wrap) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Pixel storage: write port only, no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_mem] <= i_in_data;
        end
    end

    // Raster write pointer and write bank.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_addr <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_wr_fire) begin
            if (w_wr_wrap) begin
                r_wr_addr <= '0;
                r_wr_bank <= r_wr_bank ^ PING_PONG;
            end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // Raster read pointer and read bank.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_addr <= '0;
            r_rd_bank <= 1'b0;
        end else if (w_rd_fire) begin
            if (w_rd_wrap) begin
                r_rd_addr <= '0;
                r_rd_bank <= r_rd_bank ^ PING_PONG;
            end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // Frame-complete flags per bank; reset discards every frame held.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Registered RAM read; out_data holds its value when no read is served.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_ready <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_ready <= w_rd_fire;
            r_out_last  <= w_rd_fire && w_rd_wrap;
            if (w_rd_fire) begin
                r_out_data <= r_mem[w_rd_mem];
            end
        end
    end

    assign o_in_full     = w_in_full;
    assign o_frame_avail = w_frame_avail;
    assign o_out_ready   = r_out_ready;
    assign o_out_last    = r_out_last;
    assign o_out_data    = r_out_data;

endmodule

// File: tb/tb_frame_bram_buffer.sv
// Purpose: bench for frame_bram_buffer with a single-bank and a ping-pong instance on a 4x2 frame.
// Latency: expected read data is queued when a request is driven and popped 1 cycle later.
// Backpressure: covers dropped writes while full and ignored reads while no frame is available.
module tb_frame_bram_buffer;

    logic       clk;
    // single-bank instance
    logic       rst1_n, en1, req1;
    logic [7:0] d1;
    logic       full1, rdy1, last1, avail1;
    logic [7:0] q1;
    // ping-pong instance
    logic       rst2_n, en2, req2;
    logic [7:0] d2;
    logic       full2, rdy2, last2, avail2;
    logic [7:0] q2;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb[$];   // {last, data}

    frame_bram_buffer #(
        .DATA_WIDTH(8), .IM_WIDTH(4), .IM_HEIGHT(2), .ADDR_WIDTH(3), .BANKS(1)
    ) u1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_in_enable(en1), .i_in_data(d1),
        .o_in_full(full1), .i_out_request(req1), .o_out_ready(rdy1),
        .o_out_data(q1), .o_out_last(last1), .o_frame_avail(avail1)
    );

    frame_bram_buffer #(
        .DATA_WIDTH(8), .IM_WIDTH(4), .IM_HEIGHT(2), .ADDR_WIDTH(3), .BANKS(2)
    ) u2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_in_enable(en2), .i_in_data(d2),
        .o_in_full(full2), .i_out_request(req2), .o_out_ready(rdy2),
        .o_out_data(q2), .o_out_last(last2), .o_frame_avail(avail2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst2_n = 1'b0;
        en1 = 1'b1; en2 = 1'b1; req1 = 1'b1; req2 = 1'b1;
        d1 = 8'hFF; d2 = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({full1, rdy1, last1, avail1, q1} !== 12'h000) begin
                errors++;
                $display("FAIL reset_u1 cycle %0d: got %h want 000", c, {full1, rdy1, last1, avail1, q1});
            end
            checks++;
            if ({full2, rdy2, last2, avail2, q2} !== 12'h000) begin
                errors++;
                $display("FAIL reset_u2 cycle %0d: got %h want 000", c, {full2, rdy2, last2, avail2, q2});
            end
        end
        rst1_n = 1'b1; rst2_n = 1'b1;
        en1 = 1'b0; en2 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        tick();
        // partial frame, then a one-cycle reset mid-frame
        for (int i = 0; i < 3; i++) begin
            en1 = 1'b1; d1 = 8'h55 + 8'(i);
            tick();
        end
        rst1_n = 1'b0;
        tick();
        checks++;
        if ({full1, rdy1, last1, avail1, q1} !== 12'h000) begin
            errors++;
            $display("FAIL reset_midframe: got %h want 000", {full1, rdy1, last1, avail1, q1});
        end
        rst1_n = 1'b1; en1 = 1'b0;
        tick();
    endtask

    task automatic test_empty_request();
        req2 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (rdy2 !== 1'b0 || avail2 !== 1'b0) begin
                errors++;
                $display("FAIL empty_request cycle %0d: ready=%b avail=%b want 0 0", c, rdy2, avail2);
            end
        end
        req2 = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [8:0] exp;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            en1 = 1'b1; d1 = 8'h10 + 8'(i);
            tick();
            checks++;
            if (avail1 !== (i == 7) || full1 !== (i == 7)) begin
                errors++;
                $display("FAIL single_write pixel %0d: avail=%b full=%b want %b", i, avail1, full1, i == 7);
            end
        end
        en1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 8'h10 + 8'(i);
            req1 = 1'b1; sb.push_back({i == 7, v});
            tick();
            exp = sb.pop_front();
            checks++;
            if (rdy1 !== 1'b1 || q1 !== exp[7:0] || last1 !== exp[8]) begin
                errors++;
                $display("FAIL single_read pixel %0d: ready=%b data=%h last=%b want 1 %h %b", i, rdy1, q1, last1, exp[7:0], exp[8]);
            end
        end
        checks++;
        if (avail1 !== 1'b0 || full1 !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: avail=%b full=%b want 0 0", avail1, full1);
        end
        // request with nothing available: ignored, data holds
        tick();
        checks++;
        if (rdy1 !== 1'b0 || last1 !== 1'b0 || q1 !== 8'h17) begin
            errors++;
            $display("FAIL single_ignored: ready=%b last=%b data=%h want 0 0 17", rdy1, last1, q1);
        end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [8:0] exp;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            en1 = 1'b1; d1 = 8'h10 + 8'(i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            en1 = 1'b1; d1 = 8'hAA;
            tick();
            checks++;
            if (full1 !== 1'b1) begin
                errors++;
                $display("FAIL overflow_full %0d: full=%b want 1", i, full1);
            end
        end
        en1 = 1'b0;
        // last read coincides with a write that must be dropped
        for (int i = 0; i < 8; i++) begin
            v = 8'h10 + 8'(i);
            req1 = 1'b1; sb.push_back({i == 7, v});
            if (i == 7) begin
                en1 = 1'b1; d1 = 8'hEE;
            end
            tick();
            exp = sb.pop_front();
            checks++;
            if (rdy1 !== 1'b1 || q1 !== exp[7:0] || last1 !== exp[8]) begin
                errors++;
                $display("FAIL overflow_read1 pixel %0d: ready=%b data=%h last=%b want 1 %h %b", i, rdy1, q1, last1, exp[7:0], exp[8]);
            end
        end
        req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en1 = 1'b1; d1 = 8'h20 + 8'(i);
            tick();
        end
        en1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = 8'h20 + 8'(i);
            req1 = 1'b1; sb.push_back({i == 7, v});
            tick();
            exp = sb.pop_front();
            checks++;
            if (rdy1 !== 1'b1 || q1 !== exp[7:0] || last1 !== exp[8]) begin
                errors++;
                $display("FAIL overflow_read2 pixel %0d: ready=%b data=%h last=%b want 1 %h %b", i, rdy1, q1, last1, exp[7:0], exp[8]);
            end
        end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_ping_pong();
        logic [8:0] exp;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            en2 = 1'b1; d2 = 8'(i);
            req2 = (i == 7);   // request in the cycle the bank becomes full
            tick();
            if (i == 7) begin
                checks++;
                if (avail2 !== 1'b1 || full2 !== 1'b0 || rdy2 !== 1'b0) begin
                    errors++;
                    $display("FAIL pingpong_frameA: avail=%b full=%b ready=%b want 1 0 0", avail2, full2, rdy2);
                end
            end
        end
        req2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en2 = 1'b1; d2 = 8'h40 + 8'(i);
            tick();
        end
        en2 = 1'b0;
        checks++;
        if (full2 !== 1'b1 || avail2 !== 1'b1) begin
            errors++;
            $display("FAIL pingpong_frameB: full=%b avail=%b want 1 1", full2, avail2);
        end
        for (int i = 0; i < 16; i++) begin
            v = (i < 8) ? 8'(i) : 8'h40 + 8'(i - 8);
            req2 = 1'b1; sb.push_back({(i == 7) || (i == 15), v});
            tick();
            exp = sb.pop_front();
            checks++;
            if (rdy2 !== 1'b1 || q2 !== exp[7:0] || last2 !== exp[8]) begin
                errors++;
                $display("FAIL pingpong_read pixel %0d: ready=%b data=%h last=%b want 1 %h %b", i, rdy2, q2, last2, exp[7:0], exp[8]);
            end
        end
        req2 = 1'b0;
        checks++;
        if (avail2 !== 1'b0 || full2 !== 1'b0) begin
            errors++;
            $display("FAIL pingpong_drain: avail=%b full=%b want 0 0", avail2, full2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            en2 = 1'b1; d2 = 8'h80 + 8'(i);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            en2 = (i < 8); d2 = 8'hC0 + 8'(i);
            v = (i < 8) ? 8'h80 + 8'(i) : 8'hC0 + 8'(i - 8);
            req2 = 1'b1; sb.push_back({(i == 7) || (i == 15), v});
            tick();
            exp = sb.pop_front();
            checks++;
            if (rdy2 !== 1'b1 || q2 !== exp[7:0] || last2 !== exp[8]) begin
                errors++;
                $display("FAIL stream_read pixel %0d: ready=%b data=%h last=%b want 1 %h %b", i, rdy2, q2, last2, exp[7:0], exp[8]);
            end
            if (i < 8) begin
                checks++;
                if (full2 !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_in_full cycle %0d: full=%b want 0", i, full2);
                end
            end
        end
        en2 = 1'b0; req2 = 1'b0;
        checks++;
        if (avail2 !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: avail=%b want 0", avail2);
        end
        tick();
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        en1 = 1'b0; en2 = 1'b0; req1 = 1'b0; req2 = 1'b0;
        d1 = 8'h00; d2 = 8'h00;
        test_reset();
        test_empty_request();
        test_single_frame();
        test_overflow();
        test_ping_pong();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
